track_motor_ctrl: RTL and testbench

// - Pan/tilt stepper sequencer behind the red-target tracker.
// - Takes per-frame aim point (aim_x/aim_y), detect flag and 3 s lost flag (target_off);

---
 rtl/track_motor_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_track_motor_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/track_motor_ctrl.sv
// Pan/tilt stepper sequencer: servos the tracker aim point to screen centre, with coast/search/home recovery.
// Optional pan search sweep is compiled in when TRACK_SCAN_EN is defined; otherwise a lost target homes both axes.

module track_motor_axis #(
  parameter int DIV_FAST  = 25000,
  parameter int DIV_SLOW  = 100000,
  parameter int PULSE_W   = 50,
  parameter int DIR_SETUP = 25,
  parameter int LIMIT     = 2000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               dir_req,
  input  logic               fast,
  output logic               step,
  output logic               dir,
  output logic signed [15:0] pos
);
  localparam int CW = 24;
  localparam logic signed [15:0] POS_LIM = 16'(LIMIT);
  localparam logic signed [15:0] NEG_LIM = -POS_LIM;

  logic [CW-1:0]      per_cnt_q, per_cnt_d, period_m1;
  logic [15:0]        setup_cnt_q, setup_cnt_d;
  logic [15:0]        pulse_cnt_q, pulse_cnt_d;
  logic               step_q, step_d, dir_q, dir_d;
  logic signed [15:0] pos_q, pos_d;
  logic               at_limit;

  always_comb begin
    period_m1   = fast ? CW'(DIV_FAST - 1) : CW'(DIV_SLOW - 1);
    at_limit    = dir_q ? (pos_q >= POS_LIM) : (pos_q <= NEG_LIM);
    step_d      = step_q;
    dir_d       = dir_q;
    pos_d       = pos_q;
    pulse_cnt_d = pulse_cnt_q;
    per_cnt_d   = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + CW'(1);
    setup_cnt_d = (setup_cnt_q != 16'd0) ? setup_cnt_q - 16'd1 : 16'd0;
    // A running pulse always finishes; dir is only allowed to move while STEP is low.
    if (step_q) begin
      if (pulse_cnt_q == 16'd0) step_d = 1'b0;
      else                      pulse_cnt_d = pulse_cnt_q - 16'd1;
    end else if (req && (dir_req != dir_q)) begin
      dir_d       = dir_req;
      setup_cnt_d = 16'(DIR_SETUP - 1);
    end else if (req && (setup_cnt_q == 16'd0) && (per_cnt_q >= period_m1) && !at_limit) begin
      step_d      = 1'b1;
      pulse_cnt_d = 16'(PULSE_W - 1);
      per_cnt_d   = '0;
      pos_d       = dir_q ? pos_q + 16'sd1 : pos_q - 16'sd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      per_cnt_q   <= '0;
      setup_cnt_q <= '0;
      pulse_cnt_q <= '0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      pos_q       <= '0;
    end else begin
      per_cnt_q   <= per_cnt_d;
      setup_cnt_q <= setup_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      pos_q       <= pos_d;
    end
  end

  assign step = step_q;
  assign dir  = dir_q;
  assign pos  = pos_q;
endmodule

module track_motor_ctrl #(
  parameter int CENTER_X   = 320,
  parameter int CENTER_Y   = 240,
  parameter int DEADBAND   = 10,
  parameter int BIG_ERR    = 80,
  parameter int DIV_FAST   = 25000,
  parameter int DIV_SLOW   = 100000,
  parameter int PULSE_W    = 50,
  parameter int DIR_SETUP  = 25,
  parameter int PAN_LIMIT  = 2000,
  parameter int TILT_LIMIT = 800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [9:0]  aim_x,
  input  logic [9:0]  aim_y,
  input  logic        aim_detected,
  input  logic        target_off,
  output logic        pan_step,
  output logic        pan_dir,
  output logic        tilt_step,
  output logic        tilt_dir,
  output logic [15:0] pan_pos,
  output logic [15:0] tilt_pos,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRACK = 3'd1,
    S_COAST = 3'd2,
    S_SCAN  = 3'd3,
    S_HOME  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic signed [10:0] ex_q, ex_d, ey_q, ey_d;
  logic [10:0]        ax_abs, ay_abs;
  logic               pan_req, pan_dir_req, pan_fast;
  logic               tilt_req, tilt_dir_req, tilt_fast;
  logic signed [15:0] pan_pos_w, tilt_pos_w;
`ifdef TRACK_SCAN_EN
  localparam logic signed [15:0] PAN_HI = 16'(PAN_LIMIT);
  localparam logic signed [15:0] PAN_LO = -PAN_HI;
  logic scan_dir_q, scan_dir_d;
`endif

  always_comb begin
    ex_d   = 11'({1'b0, aim_x}) - 11'(CENTER_X);
    ey_d   = 11'({1'b0, aim_y}) - 11'(CENTER_Y);
    ax_abs = ex_q[10] ? 11'(-ex_q) : 11'(ex_q);
    ay_abs = ey_q[10] ? 11'(-ey_q) : 11'(ey_q);
  end

  // Detection outranks the lost flag; dropping enable wins over everything.
  always_comb begin
    state_d = state_q;
    if (!enable) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (aim_detected) state_d = S_TRACK;
        S_TRACK: if (!aim_detected) state_d = S_COAST;
        S_COAST: begin
          if (aim_detected) state_d = S_TRACK;
`ifdef TRACK_SCAN_EN
          else if (target_off) state_d = S_SCAN;
`else
          else if (target_off) state_d = S_HOME;
`endif
        end
        default: if (aim_detected) state_d = S_TRACK;
      endcase
    end
  end

`ifdef TRACK_SCAN_EN
  // Sweep starts toward +limit on every entry and bounces at either end.
  always_comb begin
    scan_dir_d = scan_dir_q;
    if (state_q != S_SCAN)      scan_dir_d = 1'b1;
    else if (pan_pos_w >= PAN_HI) scan_dir_d = 1'b0;
    else if (pan_pos_w <= PAN_LO) scan_dir_d = 1'b1;
  end
`endif

  always_comb begin
    pan_req      = 1'b0;
    pan_dir_req  = 1'b0;
    pan_fast     = 1'b0;
    tilt_req     = 1'b0;
    tilt_dir_req = 1'b0;
    tilt_fast    = 1'b0;
    case (state_q)
      S_TRACK: begin
        pan_req      = ax_abs > 11'(DEADBAND);
        pan_dir_req  = !ex_q[10];
        pan_fast     = ax_abs > 11'(BIG_ERR);
        tilt_req     = ay_abs > 11'(DEADBAND);
        tilt_dir_req = !ey_q[10];
        tilt_fast    = ay_abs > 11'(BIG_ERR);
      end
`ifdef TRACK_SCAN_EN
      S_SCAN: begin
        pan_req      = scan_dir_q ? (pan_pos_w < PAN_HI) : (pan_pos_w > PAN_LO);
        pan_dir_req  = scan_dir_q;
        tilt_req     = tilt_pos_w != 16'sd0;
        tilt_dir_req = tilt_pos_w < 16'sd0;
      end
`endif
      S_HOME: begin
        pan_req      = pan_pos_w != 16'sd0;
        pan_dir_req  = pan_pos_w < 16'sd0;
        tilt_req     = tilt_pos_w != 16'sd0;
        tilt_dir_req = tilt_pos_w < 16'sd0;
      end
      default: ;
    endcase
    if (!enable) begin
      pan_req  = 1'b0;
      tilt_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ex_q       <= '0;
      ey_q       <= '0;
`ifdef TRACK_SCAN_EN
      scan_dir_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      ex_q       <= ex_d;
      ey_q       <= ey_d;
`ifdef TRACK_SCAN_EN
      scan_dir_q <= scan_dir_d;
`endif
    end
  end

  track_motor_axis #(.DIV_FAST(DIV_FAST), .DIV_SLOW(DIV_SLOW), .PULSE_W(PULSE_W),
                     .DIR_SETUP(DIR_SETUP), .LIMIT(PAN_LIMIT)) u_pan (
    .clk(clk), .reset(reset), .req(pan_req), .dir_req(pan_dir_req), .fast(pan_fast),
    .step(pan_step), .dir(pan_dir), .pos(pan_pos_w));

  track_motor_axis #(.DIV_FAST(DIV_FAST), .DIV_SLOW(DIV_SLOW), .PULSE_W(PULSE_W),
                     .DIR_SETUP(DIR_SETUP), .LIMIT(TILT_LIMIT)) u_tilt (
    .clk(clk), .reset(reset), .req(tilt_req), .dir_req(tilt_dir_req), .fast(tilt_fast),
    .step(tilt_step), .dir(tilt_dir), .pos(tilt_pos_w));

  assign pan_pos  = pan_pos_w;
  assign tilt_pos = tilt_pos_w;
  assign state    = state_q;
endmodule

// File: tb/tb_track_motor_ctrl.sv
// Bench for track_motor_ctrl with shortened step timing; pan step events are scoreboarded.
// Builds with or without TRACK_SCAN_EN to match the DUT.
`timescale 1ns/1ps
module tb_track_motor_ctrl;
  localparam int DIV_FAST   = 40;
  localparam int DIV_SLOW   = 100;
  localparam int PULSE_W    = 5;
  localparam int DIR_SETUP  = 3;
  localparam int PAN_LIMIT  = 20;
  localparam int TILT_LIMIT = 10;
  localparam int W          = 41;

  // clock / reset / DUT
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        aim_detected = 1'b0;
  logic        target_off = 1'b0;
  logic [9:0]  aim_x = 10'd320;
  logic [9:0]  aim_y = 10'd240;
  logic        pan_step, pan_dir, tilt_step, tilt_dir;
  logic [15:0] pan_pos, tilt_pos;
  logic [2:0]  state;

  always #5 clk = ~clk;

  track_motor_ctrl #(
    .DIV_FAST(DIV_FAST), .DIV_SLOW(DIV_SLOW), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP),
    .PAN_LIMIT(PAN_LIMIT), .TILT_LIMIT(TILT_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .aim_x(aim_x), .aim_y(aim_y),
    .aim_detected(aim_detected), .target_off(target_off),
    .pan_step(pan_step), .pan_dir(pan_dir), .tilt_step(tilt_step), .tilt_dir(tilt_dir),
    .pan_pos(pan_pos), .tilt_pos(tilt_pos), .state(state)
  );

  // scoreboard: {dir, pos[15:0], interval[23:0]}, interval 0 = not checked
  logic [W-1:0] exp_q[$];
  int check_cnt = 0;
  int err_cnt   = 0;
  int cyc       = 0;
  int unexp_cnt = 0;
  int tilt_rises = 0;
  bit pw_chk_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] pos32(input int v);
    logic [15:0] t;
    t = v[15:0];
    return {16'd0, t};
  endfunction

  task automatic push_exp(input bit d, input int p, input int iv);
    exp_q.push_back({d, p[15:0], iv[23:0]});
  endtask

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_pan_step", 32'(pan_step), 32'd0);
    chk("rst_pan_dir", 32'(pan_dir), 32'd0);
    chk("rst_tilt_step", 32'(tilt_step), 32'd0);
    chk("rst_tilt_dir", 32'(tilt_dir), 32'd0);
    chk("rst_pan_pos", 32'(pan_pos), 32'd0);
    chk("rst_tilt_pos", 32'(tilt_pos), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
  endtask

  initial forever @(posedge clk) cyc++;

  // monitor: pops one expected event per pan step rise, checks width and dir setup
  initial begin
    logic         pan_step_p, pan_dir_p, tilt_step_p;
    logic [W-1:0] item;
    int           last_rise, dir_chg, high_cnt;
    pan_step_p = 1'b0; pan_dir_p = 1'b0; tilt_step_p = 1'b0;
    last_rise = 0; dir_chg = 0; high_cnt = 0;
    forever begin
      @(negedge clk);
      if (pan_dir !== pan_dir_p) dir_chg = cyc;
      if (pan_step === 1'b1 && pan_step_p === 1'b0) begin
        chk("pan_dir_setup", 32'((cyc - dir_chg) >= DIR_SETUP), 32'd1);
        if (exp_q.size() == 0) unexp_cnt++;
        else begin
          item = exp_q.pop_front();
          chk("pan_dir", 32'(pan_dir), 32'(item[40]));
          chk("pan_pos", 32'(pan_pos), {16'd0, item[39:24]});
          if (item[23:0] != 24'd0) chk("pan_period", 32'(cyc - last_rise), {8'd0, item[23:0]});
        end
        last_rise = cyc;
        high_cnt  = 0;
      end
      if (pan_step === 1'b1) high_cnt++;
      if (pan_step === 1'b0 && pan_step_p === 1'b1 && pw_chk_en)
        chk("pan_pulse_w", 32'(high_cnt), 32'(PULSE_W));
      if (tilt_step === 1'b1 && tilt_step_p === 1'b0) tilt_rises++;
      pan_step_p  = pan_step;
      pan_dir_p   = pan_dir;
      tilt_step_p = tilt_step;
    end
  end

  // stimulus
  initial begin
    int t0, pe;
    // reset and centred target
    cycles(3);
    chk_all_zero();
    reset = 1'b1; enable = 1'b1; aim_detected = 1'b1;
    cycles(2);
    chk("track_entry", 32'(state), 32'd1);
    cycles(50);
    chk("centred_pan_pos", 32'(pan_pos), 32'd0);

    // fast, then slow, then deadband
    aim_x = 10'd500;
    push_exp(1, 1, 0); push_exp(1, 2, DIV_FAST); push_exp(1, 3, DIV_FAST); push_exp(1, 4, DIV_FAST);
    wait_drain(1000);
    aim_x = 10'd360;
    push_exp(1, 5, 0); push_exp(1, 6, DIV_SLOW);
    wait_drain(1000);
    aim_x = 10'd325;
    cycles(300);
    chk("deadband_pan_pos", 32'(pan_pos), pos32(6));
    chk("deadband_pan_dir", 32'(pan_dir), 32'd1);

    // direction reversal
    aim_x = 10'd500;
    push_exp(1, 7, 0);
    wait_drain(500);
    aim_x = 10'd100;
    push_exp(0, 6, 0); push_exp(0, 5, DIV_FAST); push_exp(0, 4, DIV_FAST);
    wait_drain(1000);

    // pan soft limit, tilt servo
    t0 = tilt_rises;
    aim_x = 10'd600; aim_y = 10'd300;
    push_exp(1, 5, 0);
    for (int i = 6; i <= PAN_LIMIT; i++) push_exp(1, i, DIV_FAST);
    wait_drain(2000);
    cycles(200);
    aim_y = 10'd240;
    cycles(20);
    chk("limit_pan_pos", 32'(pan_pos), pos32(PAN_LIMIT));
    chk("tilt_pos_count", 32'(tilt_pos), pos32(tilt_rises - t0));
    chk("tilt_dir", 32'(tilt_dir), 32'd1);
    chk("tilt_moved", 32'(tilt_pos != 16'd0), 32'd1);

    // lost target: coast, then search/home
    aim_detected = 1'b0;
    cycles(2);
    chk("coast_state", 32'(state), 32'd2);
    cycles(200);
    chk("coast_pan_pos", 32'(pan_pos), pos32(PAN_LIMIT));
    target_off = 1'b1;
    push_exp(0, PAN_LIMIT - 1, 0);
`ifdef TRACK_SCAN_EN
    for (int i = PAN_LIMIT - 2; i >= -PAN_LIMIT; i--) push_exp(0, i, DIV_SLOW);
    push_exp(1, -PAN_LIMIT + 1, DIV_SLOW); push_exp(1, -PAN_LIMIT + 2, DIV_SLOW);
    pe = -PAN_LIMIT + 2;
    cycles(2);
    chk("scan_state", 32'(state), 32'd3);
`else
    for (int i = PAN_LIMIT - 2; i >= 0; i--) push_exp(0, i, DIV_SLOW);
    pe = 0;
    cycles(2);
    chk("home_state", 32'(state), 32'd4);
`endif
    wait_drain(8000);
    aim_detected = 1'b1; target_off = 1'b0; aim_x = 10'd320; aim_y = 10'd240;
    cycles(2);
    chk("reacquire_state", 32'(state), 32'd1);
    cycles(200);
    chk("recover_pan_pos", 32'(pan_pos), pos32(pe));
    chk("recover_tilt_pos", 32'(tilt_pos), 32'd0);

    // enable dropped mid-pulse
    aim_x = 10'd500;
    push_exp(1, pe + 1, 0);
    wait_drain(500);
    enable = 1'b0;
    cycles(2);
    chk("disable_state", 32'(state), 32'd0);
    cycles(200);
    chk("disable_pan_pos", 32'(pan_pos), pos32(pe + 1));
    chk("disable_pan_step", 32'(pan_step), 32'd0);
    enable = 1'b1;
    push_exp(1, pe + 2, 0);
    wait_drain(500);

    // reset mid-pulse cuts the pulse and clears position
    pw_chk_en = 1'b0;
    reset = 1'b0;
    cycles(1);
    chk_all_zero();
    reset = 1'b1; enable = 1'b0;
    cycles(5);
    pw_chk_en = 1'b1;

    chk("pan_unexpected_steps", 32'(unexp_cnt), 32'd0);
    chk("exp_q_left", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end
endmodule
